axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter G_DATAWIDTH, default 32, AXI data width in bits (32 or 64).
REQ-002 SHALL have parameter G_ID_WIDTH, default 1, AXI ID width.
REQ-003 SHALL have parameter G_ID_VALUE, default 0, ID driven on m_axi_awid/m_axi_arid.
REQ-004 SHALL have port m_aclk input 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port m_areset input 1, synchronous active-high reset.
REQ-006 SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in 32 (byte address), cmd_len in 8 (beats minus one).
REQ-007 SHALL have write-data ports: wr_data in G_DATAWIDTH, wr_valid in 1, wr_ready out 1.
REQ-008 SHALL have read-data ports: rd_data out G_DATAWIDTH, rd_valid out 1, rd_ready in 1, rd_last out 1.
REQ-009 SHALL have status ports: done out 1 (one-cycle completion pulse), err out 1 (sticky error).
REQ-010 SHALL have AXI4 master ports m_axi_aw{id,addr[31:0],len[7:0],size[2:0],burst[1:0],valid,ready}, m_axi_w{data,strb[G_DATAWIDTH/8],last,valid,ready}, m_axi_b{id,resp[1:0],valid,ready}, m_axi_ar{id,addr,len,size,burst,valid,ready}, m_axi_r{id,data,resp,last,valid,ready}, directions per AXI master.

Function
REQ-011 SHALL implement states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA; one transaction outstanding at a time.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready captures addr, len, write and moves to WADDR (write) or RADDR (read).
REQ-013 SHALL drive awvalid/arvalid registered, high from the cycle after command accept until the cycle after awready/arready handshake.
REQ-014 SHALL drive awaddr/araddr=captured cmd_addr unmodified, aw/arlen=captured cmd_len, aw/arsize=log2(G_DATAWIDTH/8), aw/arburst=2'b01 (INCR), wstrb all ones; 4 KB boundary and alignment are caller responsibility.
REQ-015 SHALL, on AW handshake, enter WDATA; in WDATA m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, m_axi_wdata=wr_data, combinational pass-through; wr_ready=0 outside WDATA.
REQ-016 SHALL count accepted W beats in an 8-bit counter cleared on command accept; m_axi_wlast=1 when count==captured len; cmd_len=255 yields 256 beats with no counter wrap error.
REQ-017 SHALL, on W handshake with wlast, enter WRESP; bready=1 only in WRESP; on bvalid enter IDLE and pulse done for one cycle.
REQ-018 SHALL, on AR handshake, enter RDATA; rd_valid=rvalid, m_axi_rready=rd_ready, rd_data=rdata, rd_last=rlast, pass-through; rready=0 outside RDATA.
REQ-019 SHALL, on R handshake with rlast, enter IDLE and pulse done one cycle after that handshake.
REQ-020 SHALL ignore cmd_valid while not in IDLE; a new command is accepted no earlier than the cycle done is high.
REQ-021 SHALL not deassert awvalid/arvalid before handshake, and hold aw/ar payload stable while valid.

Reset
REQ-022 SHALL, on m_areset=1 at a clock edge, enter IDLE and clear awvalid, arvalid, done, err, beat counter, captured fields to 0.
REQ-023 SHALL, when reset is asserted mid-transaction, abandon it without completing the burst; combinational pass-through readies/valids SHALL be 0 in the cycle following reset.

Configuration
REQ-024 SHALL, with macro AXI_BURST_MASTER_RESP_CHECK_EN defined, set err on bresp!=0, rresp!=0, bid/rid!=G_ID_VALUE, or rlast mismatching beat count==len; err clears only on reset.
REQ-025 SHALL, without AXI_BURST_MASTER_RESP_CHECK_EN, tie err to 0 and omit check logic; all other behaviour identical.

Verification
REQ-026 Write addr=0x100 len=3, slave always ready -> AW at 0x100 awlen=3 awsize=2, 4 W beats, wlast on 4th, bready, done one pulse, err=0.
REQ-027 Read addr=0x40 len=0 after writing 0xDEADBEEF there -> arlen=0, one rd beat 0xDEADBEEF with rd_last=1, done pulse.
REQ-028 Write len=255 with random wready/wr_valid gaps -> exactly 256 W handshakes, wlast only on 256th, no data lost or duplicated.
REQ-029 cmd_valid held high during active read -> second command accepted only in IDLE after first done; no overlap of arvalid.
REQ-030 Reset asserted during WDATA beat 2 of len=7 -> next cycle awvalid=wvalid=wr_ready=0, state IDLE, cmd_ready=1.
REQ-031 With RESP_CHECK_EN, slave returns bresp=2'b10 -> err=1 sticky after done; without macro err=0.

Source files
------------

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command in, one INCR burst out, done pulse on completion.
// Optional response/ID/last checking is enabled with `define AXI_BURST_MASTER_RESP_CHECK_EN.
module axi_burst_master #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ID_WIDTH  = 1,
  parameter int G_ID_VALUE  = 0
) (
  input  logic                     m_aclk,
  input  logic                     m_areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [31:0]              cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [G_DATAWIDTH-1:0]   wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [G_DATAWIDTH-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     done,
  output logic                     err,
  output logic [G_ID_WIDTH-1:0]    m_axi_awid,
  output logic [31:0]              m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [G_DATAWIDTH-1:0]   m_axi_wdata,
  output logic [G_DATAWIDTH/8-1:0] m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]    m_axi_bid,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [G_ID_WIDTH-1:0]    m_axi_arid,
  output logic [31:0]              m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]    m_axi_rid,
  input  logic [G_DATAWIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam logic [2:0]            SIZE_C = 3'($clog2(G_DATAWIDTH/8));
  localparam logic [G_ID_WIDTH-1:0] ID_C   = G_ID_WIDTH'(G_ID_VALUE);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic        awvalid_q, arvalid_q, done_q;
  logic        cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_hs;

  assign m_axi_awid    = ID_C;
  assign m_axi_arid    = ID_C;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_awsize  = SIZE_C;
  assign m_axi_arsize  = SIZE_C;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == S_WDATA) && (cnt_q == len_q);
  assign rd_data       = m_axi_rdata;
  assign rd_last       = m_axi_rlast;
  assign done          = done_q;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = awvalid_q && m_axi_awready;
  assign ar_hs  = arvalid_q && m_axi_arready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge m_aclk) begin
    if (m_areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake pass-throughs are gated by state so a freshly reset master drives nothing.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rready = 1'b0;
    rd_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_write ? S_WADDR : S_RADDR;
      end
      S_WADDR: if (awvalid_q && m_axi_awready) state_d = S_WDATA;
      S_WDATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        if (wr_valid && m_axi_wready && (cnt_q == len_q)) state_d = S_WRESP;
      end
      S_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = S_IDLE;
      end
      S_RADDR: if (arvalid_q && m_axi_arready) state_d = S_RDATA;
      S_RDATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (m_axi_rvalid && rd_ready && m_axi_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat counter is shared by both directions; it may wrap after beat 256 but the state has left by then.
  always_ff @(posedge m_aclk) begin
    if (m_areset) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cmd_hs) begin
        addr_q    <= cmd_addr;
        len_q     <= cmd_len;
        cnt_q     <= '0;
        awvalid_q <= cmd_write;
        arvalid_q <= ~cmd_write;
      end
      if (aw_hs) awvalid_q <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      if (w_hs || r_hs) cnt_q <= cnt_q + 8'd1;
      if (b_hs || (r_hs && m_axi_rlast)) done_q <= 1'b1;
    end
  end

`ifdef AXI_BURST_MASTER_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge m_aclk) begin
    if (m_areset) begin
      err_q <= 1'b0;
    end else if ((b_hs && ((m_axi_bresp != 2'b00) || (m_axi_bid != ID_C))) ||
                 (r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rid != ID_C) ||
                           (m_axi_rlast != (cnt_q == len_q))))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_resp;

  assign unused_resp = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp};
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: vector table of bursts against a memory slave model, plus reset,
// back-to-back command and error-response sequences.
module tb_axi_burst_master;

  localparam int DW = 32;
`ifdef AXI_BURST_MASTER_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          m_areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [31:0]   cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic          done, err;
  logic [0:0]    m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [31:0]   m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master #(.G_DATAWIDTH(DW), .G_ID_WIDTH(1), .G_ID_VALUE(0)) dut (
    .m_aclk(clk), .m_areset(m_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ax_t;
  typedef struct packed {logic [31:0] d; logic l;} rexp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [7:0] len; logic [31:0] base; int gap; logic exp_err;} vec_t;

  ax_t         awq[$], arq[$];
  logic [31:0] drv_q[$], exp_w[$];
  rexp_t       rq[$];
  logic [31:0] ref_mem [int];
  logic [31:0] smem [int];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_end_cyc = 0;
  int w_cnt = 0, ar_cnt = 0, rd_cnt = 0;
  int wgap = 0, sgap = 0, rgap = 0;
  logic [1:0] bresp_cfg = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic roll(input int gap);
    return (gap == 0) || ($urandom_range(99) >= gap);
  endfunction

  // Memory slave: drives at the falling edge, observes handshakes just after.
  initial begin
    bit b_pend = 0, r_pend = 0;
    int w_idx = 0, r_idx = 0;
    logic [31:0] aw_addr_s = '0, ar_addr_s = '0;
    logic [7:0]  aw_len_s = '0, ar_len_s = '0;
    ax_t e;
    logic [31:0] d;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rid = 0;
    forever begin
      @(negedge clk);
      m_axi_awready = roll(sgap);
      m_axi_wready  = roll(sgap);
      m_axi_arready = roll(sgap);
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = bresp_cfg;
      m_axi_rvalid  = r_pend && roll(sgap);
      m_axi_rdata   = smem.exists(int'(ar_addr_s[31:2]) + r_idx) ? smem[int'(ar_addr_s[31:2]) + r_idx] : 32'h0;
      m_axi_rlast   = (r_idx == int'(ar_len_s));
      #1;
      if (m_areset) begin
        b_pend = 0; r_pend = 0; w_idx = 0; r_idx = 0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin
          if (awq.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            e = awq.pop_front();
            chk("awaddr", m_axi_awaddr, e.addr);
            chk("awlen", m_axi_awlen, e.len);
            chk("awsize", m_axi_awsize, 3'd2);
            chk("awburst", m_axi_awburst, 2'b01);
            chk("awid", m_axi_awid, 1'b0);
          end
          aw_addr_s = m_axi_awaddr; aw_len_s = m_axi_awlen; w_idx = 0;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_pend = 0;
          last_end_cyc = cyc;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            d = exp_w.pop_front();
            chk("wdata", m_axi_wdata, d);
          end
          chk("wlast", m_axi_wlast, (w_idx == int'(aw_len_s)));
          if (w_idx == 0) chk("wstrb", m_axi_wstrb, 4'hF);
          smem[int'(aw_addr_s[31:2]) + w_idx] = m_axi_wdata;
          if (m_axi_wlast) b_pend = 1;
          w_idx++;
          w_cnt++;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (arq.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            e = arq.pop_front();
            chk("araddr", m_axi_araddr, e.addr);
            chk("arlen", m_axi_arlen, e.len);
            chk("arsize", m_axi_arsize, 3'd2);
            chk("arburst", m_axi_arburst, 2'b01);
          end
          ar_addr_s = m_axi_araddr; ar_len_s = m_axi_arlen; r_idx = 0; r_pend = 1;
          ar_cnt++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          if (m_axi_rlast) r_pend = 0;
          r_idx++;
        end
      end
    end
  end

  // Write-data source
  initial begin
    wr_valid = 0; wr_data = '0;
    forever begin
      @(negedge clk);
      if (drv_q.size() > 0) begin
        wr_valid = roll(wgap);
        wr_data  = drv_q[0];
      end else begin
        wr_valid = 0;
      end
      #1;
      if (wr_valid && wr_ready) drv_q.delete(0);
    end
  end

  // Read-data sink with scoreboard compare
  initial begin
    rexp_t e;
    rd_ready = 0;
    forever begin
      @(negedge clk);
      rd_ready = roll(rgap);
      #1;
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_data", rd_data, e.d);
          chk("rd_last", rd_last, e.l);
        end
        if (rd_last) last_end_cyc = cyc;
        rd_cnt++;
      end
    end
  end

  task automatic wait_done(input string nm, output bit ok);
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      #1;
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, ok, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] base, input logic exp_err);
    int n0;
    bit ok;
    ax_t a;
    rexp_t r;
    logic [31:0] d;
    a.addr = addr;
    a.len  = len;
    if (wr) begin
      awq.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        d = base + 32'(i) * 32'h0001_0001;
        drv_q.push_back(d);
        exp_w.push_back(d);
        ref_mem[int'(addr[31:2]) + i] = d;
      end
      n0 = w_cnt;
    end else begin
      arq.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        r.d = ref_mem[int'(addr[31:2]) + i];
        r.l = (i == int'(len));
        rq.push_back(r);
      end
      n0 = rd_cnt;
    end
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("cmd_accept", ok, 1);
    @(negedge clk);
    cmd_valid = 0;
    wait_done("done_seen", ok);
    if (ok) begin
      chk("done_latency", cyc - last_end_cyc, 1);
      chk("err_at_done", err, exp_err);
    end
    chk("beat_count", wr ? (w_cnt - n0) : (rd_cnt - n0), int'(len) + 1);
    @(negedge clk);
    #1;
    chk("done_one_pulse", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    bit ok;
    int n0, acc;
    ax_t a;
    rexp_t r;

    vecs[0] = '{1'b1, 32'h0000_0100, 8'd3,   32'hA000_0000, 0,  1'b0};
    vecs[1] = '{1'b1, 32'h0000_0040, 8'd0,   32'hDEAD_BEEF, 0,  1'b0};
    vecs[2] = '{1'b0, 32'h0000_0040, 8'd0,   32'h0,         0,  1'b0};
    vecs[3] = '{1'b0, 32'h0000_0100, 8'd3,   32'h0,         30, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_1000, 8'd255, 32'h1200_0000, 40, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_1000, 8'd255, 32'h0,         30, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_2000, 8'd7,   32'h3300_0000, 20, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_2000, 8'd7,   32'h0,         0,  1'b0};

    m_areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rready", m_axi_rready, 0);
    @(negedge clk);
    m_areset = 0;

    for (int v = 0; v < 8; v++) begin
      wgap = vecs[v].gap; sgap = vecs[v].gap; rgap = vecs[v].gap;
      run_cmd(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].exp_err);
    end
    wgap = 0; sgap = 0; rgap = 0;

    // Command held valid across a read: second accept must coincide with done.
    a.addr = 32'h40; a.len = 8'd0;
    r.d = ref_mem[16]; r.l = 1'b1;
    arq.push_back(a); arq.push_back(a);
    rq.push_back(r);  rq.push_back(r);
    n0 = ar_cnt; acc = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; cmd_len = 8'd0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (cmd_ready) begin
        acc++;
        if (acc == 2) begin
          chk("accept2_with_done", done, 1);
          break;
        end
      end
      @(negedge clk);
    end
    chk("two_accepts", acc, 2);
    @(negedge clk);
    cmd_valid = 0;
    wait_done("done_seen_2nd", ok);
    chk("ar_handshakes", ar_cnt - n0, 2);

    // Reset in the middle of an 8-beat write burst.
    a.addr = 32'h3000; a.len = 8'd7;
    awq.push_back(a);
    for (int i = 0; i < 8; i++) begin
      drv_q.push_back(32'h7700_0000 + 32'(i));
      exp_w.push_back(32'h7700_0000 + 32'(i));
    end
    n0 = w_cnt;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3000; cmd_len = 8'd7;
    #1;
    chk("rst_seq_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    for (int c = 0; c < 100; c++) begin
      #2;
      if (w_cnt - n0 >= 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    m_areset = 1;
    @(negedge clk);
    #1;
    chk("midrst_awvalid", m_axi_awvalid, 0);
    chk("midrst_wvalid", m_axi_wvalid, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    #1;
    drv_q.delete();
    exp_w.delete();
    @(negedge clk);
    m_areset = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_beats_abandoned", w_cnt - n0, 2);
    chk("midrst_idle_after", cmd_ready, 1);

    // Error response from the slave.
    bresp_cfg = 2'b10;
    run_cmd(1'b1, 32'h500, 8'd1, 32'h5000_0000, EXP_ERR);
    bresp_cfg = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("err_sticky", err, EXP_ERR);
    @(negedge clk);
    m_areset = 1;
    @(negedge clk);
    #1;
    chk("err_cleared_by_reset", err, 0);
    @(negedge clk);
    m_areset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
